instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/fetch_buf.sv | 59 +++++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      WAIT_LOAD = 2'd0,
      RUN       = 2'd1,
      FAULT     = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } buf_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~(WORD_BYTES - 32'd1);
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_buf #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential prefetch into a small buffer with redirect/flush.
// Optional misaligned-redirect trap enabled by INSTR_FETCH_MISALIGN_TRAP_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        loading_done,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
   output logic        fetch_fault,
`endif
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_e  r_state, w_state_nxt;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_inflight_pc;
   logic          r_inflight;
   logic          r_inflight_ep;
   logic          r_epoch;

   logic          w_run;
   logic          w_redir;
   logic          w_pop;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [CW:0]   w_occ;
   logic [31:0]   w_target;
   logic [63:0]   w_wdata;
   logic [63:0]   w_rdata;
   buf_entry_t    w_head;

   assign w_run   = (r_state == RUN);
   assign w_redir = w_run && redirect_valid;
   assign w_pop   = instr_valid && instr_ready;

   // Occupancy after this cycle's pop; a pop frees a slot for a same-cycle request.
   assign w_occ    = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
   assign imem_req = w_run && !redirect_valid && (w_occ < (CW+1)'(BUF_DEPTH));
   assign imem_addr = r_fetch_pc;

   // Responses tagged with a stale epoch belong to a pre-redirect request.
   assign w_push  = w_run && r_inflight && (r_inflight_ep == r_epoch) && !w_redir && !w_full;
   assign w_wdata = {r_inflight_pc, imem_rdata};

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
   assign w_target    = redirect_pc;
   assign fetch_fault = (r_state == FAULT);
`else
   assign w_target = align_word(redirect_pc);
`endif

   assign w_head      = buf_entry_t'(w_rdata);
   assign instr_valid = w_run && !w_empty;
   assign instr       = instr_valid ? w_head.instr : '0;
   assign instr_pc    = instr_valid ? w_head.pc    : '0;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         WAIT_LOAD: if (loading_done) w_state_nxt = RUN;
         RUN: begin
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            if (w_redir && (redirect_pc[1:0] != 2'b00)) w_state_nxt = FAULT;
`endif
         end
         FAULT:     w_state_nxt = FAULT;
         default:   w_state_nxt = WAIT_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= WAIT_LOAD;
         r_fetch_pc    <= RESET_PC;
         r_inflight_pc <= '0;
         r_inflight    <= 1'b0;
         r_inflight_ep <= 1'b0;
         r_epoch       <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_inflight    <= imem_req;
         r_inflight_ep <= r_epoch;
         if (imem_req) r_inflight_pc <= r_fetch_pc;
         if (w_redir) begin
            r_fetch_pc <= w_target;
            r_epoch    <= ~r_epoch;
         end else if (imem_req) begin
            r_fetch_pc <= r_fetch_pc + WORD_BYTES;
         end
      end
   end

   fetch_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (64)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .i_flush (w_redir),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC-stream model checked every cycle plus directed scenarios.
module tb_instr_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        loading_done;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
   logic        fetch_fault;
   logic        w_fault;
`endif

   // second instance for the wrap-around scenario
   logic        w_ld = 1'b1;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata = '0;
   logic        w_valid;
   logic        w_ready = 1'b1;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic        w_rv = 1'b0;
   logic [31:0] w_rpc = '0;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .loading_done(loading_done),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc),
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      .fetch_fault(fetch_fault),
`endif
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst_n(rst_n), .loading_done(w_ld),
      .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
      .instr_valid(w_valid), .instr_ready(w_ready),
      .instr(w_instr), .instr_pc(w_pc),
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      .fetch_fault(w_fault),
`endif
      .redirect_valid(w_rv), .redirect_pc(w_rpc)
   );

   // memories return the word equal to its address, one cycle after the request
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= imem_addr;
      if (w_req)    w_rdata    <= w_addr;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: expected PC stream ----------------
   bit          m_loaded, m_fault, m_hold, redir, hs;
   int          m_out;
   logic [31:0] m_pc, m_next, hold_pc, hold_instr, tgt;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_req",   32'(imem_req),    0);
            chk("rst_addr",  imem_addr,        0);
            chk("rst_valid", 32'(instr_valid), 0);
            chk("rst_instr", instr,            0);
            chk("rst_pc",    instr_pc,         0);
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            chk("rst_fault", 32'(fetch_fault), 0);
`endif
            m_loaded = 0; m_fault = 0; m_hold = 0;
            m_pc = 0; m_next = 0; m_out = 0;
         end else begin
            redir = m_loaded && !m_fault && redirect_valid;
            if (!m_loaded || m_fault) begin
               chk("idle_req",   32'(imem_req),    0);
               chk("idle_valid", 32'(instr_valid), 0);
            end
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            chk("fault_flag", 32'(fetch_fault), 32'(m_fault));
`endif
            if (imem_req) chk("req_addr", imem_addr, m_pc);
            if (redir) chk("redir_noreq", 32'(imem_req), 0);
            else if (m_loaded && !m_fault && m_out < DEPTH)
               chk("req_when_room", 32'(imem_req), 1);
            if (instr_valid) chk("instr_word", instr, instr_pc);
            if (m_hold) begin
               chk("hold_valid", 32'(instr_valid), 1);
               chk("hold_pc",    instr_pc, hold_pc);
               chk("hold_instr", instr,    hold_instr);
            end
            hs = instr_valid && instr_ready;
            if (hs) begin
               chk("pc_seq", instr_pc, m_next);
               m_next = m_next + 32'd4;
               m_out--;
            end
            m_hold     = instr_valid && !instr_ready && !redir;
            hold_pc    = instr_pc;
            hold_instr = instr;
            if (redir) begin
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
               tgt = redirect_pc;
               if (redirect_pc[1:0] != 2'b00) m_fault = 1;
`else
               tgt = {redirect_pc[31:2], 2'b00};
`endif
               m_pc = tgt; m_next = tgt; m_out = 0;
            end else if (imem_req) begin
               m_pc = m_pc + 32'd4;
               m_out++;
            end
            chk("outstanding", 32'(m_out >= 0 && m_out <= DEPTH), 1);
            if (!m_loaded && loading_done) m_loaded = 1;
         end
      end
   end

   // first three PCs presented by the wrap instance
   logic [31:0] wcap [3];
   int          wcnt = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && w_valid && w_ready && wcnt < 3) begin
            wcap[wcnt] = w_pc;
            wcnt++;
         end
      end
   end

   task automatic wait_hs(input string nm, input logic [31:0] exp_pc);
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) ok = 1;
      end
      chk({nm, "_seen"}, 32'(ok), 1);
      if (ok) chk(nm, instr_pc, exp_pc);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   logic [31:0] p0, bp_pc;
   int          t, gaps;
   bit          found;

   initial begin
      rst_n = 0; loading_done = 0; instr_ready = 1;
      redirect_valid = 0; redirect_pc = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // boot: memory not yet loaded for 20 cycles; a redirect meanwhile is ignored
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         redirect_valid = (i == 10);
         redirect_pc    = 32'h40;
      end
      redirect_valid = 0;
      loading_done   = 1;
      found = 0; t = 0;
      while (!found && t < 10) begin
         @(negedge clk);
         if (imem_req) found = 1; else t++;
      end
      chk("boot_req_seen",   32'(found), 1);
      chk("boot_first_addr", imem_addr,  0);
      @(negedge clk); chk("boot_lat1_valid", 32'(instr_valid), 0);
      @(negedge clk); chk("boot_lat2_valid", 32'(instr_valid), 1);
      chk("boot_lat2_pc", instr_pc, 0);

      // streaming: one instruction per cycle
      repeat (5) @(negedge clk);
      p0 = instr_pc; gaps = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!instr_valid) gaps++;
      end
      chk("stream_gaps",    32'(gaps),     0);
      chk("stream_advance", instr_pc - p0, 32'd40);

      // backpressure
      @(posedge clk); #1 instr_ready = 0;
      @(negedge clk); bp_pc = instr_pc;
      repeat (10) @(negedge clk);
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_head",  instr_pc, bp_pc);
      @(posedge clk); #1 instr_ready = 1;
      repeat (10) @(posedge clk);

      // asynchronous reset mid-run
      #3 rst_n = 0;
      #1;
      chk("async_req",   32'(imem_req),    0);
      chk("async_valid", 32'(instr_valid), 0);
      chk("async_addr",  imem_addr,        0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // redirect while the request for 0x8 is in flight
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 32'h8) found = 1;
      end
      chk("req8_seen", 32'(found), 1);
      @(posedge clk); #1 redirect_valid = 1; redirect_pc = 32'h100;
      @(posedge clk); #1 redirect_valid = 0;
      wait_hs("redir_pc", 32'h100);

      // misaligned redirect
      repeat (5) @(posedge clk);
      #1 redirect_valid = 1; redirect_pc = 32'h102;
      @(posedge clk); #1 redirect_valid = 0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      repeat (3) @(negedge clk);
      chk("trap_fault", 32'(fetch_fault), 1);
      chk("trap_req",   32'(imem_req),    0);
`else
      wait_hs("misalign_pc", 32'h100);
`endif

      // redirect with the head held; in FAULT it must be ignored
      @(posedge clk); #1 instr_ready = 0;
      repeat (4) @(posedge clk);
      #1 redirect_valid = 1; redirect_pc = 32'h200;
      @(posedge clk); #1 redirect_valid = 0;
      repeat (2) @(posedge clk);
      #1 instr_ready = 1;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      repeat (3) @(negedge clk);
      chk("fault_sticky_req", 32'(imem_req), 0);
`else
      wait_hs("bp_redir_pc", 32'h200);
`endif
      repeat (5) @(negedge clk);

      chk("wrap_count", 32'(wcnt >= 3), 1);
      chk("wrap_pc0", wcap[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", wcap[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", wcap[2], 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
